// File: rtl/window_gen33.sv
// Streaming 3x3 window generator: buffers two previous raster lines and emits
// the 3x3 neighbourhood as three packed row words for the kernel MAC stage.
module window_gen33 #(
   parameter int unsigned PIX_W = 16,
   parameter int unsigned IMG_W = 8,
   parameter int unsigned IMG_H = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_sof,
   input  logic [PIX_W-1:0]   in_pix,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [3*PIX_W-1:0] im1,
   output logic [3*PIX_W-1:0] im2,
   output logic [3*PIX_W-1:0] im3,
   output logic               frame_done,
   output logic               sof_err
);

   localparam int unsigned CW = $clog2(IMG_W);
   localparam int unsigned RW = $clog2(IMG_H);
   localparam int unsigned WW = 3 * PIX_W;

   typedef enum logic {PRIME, STREAM} state_e;

   state_e            state_q;
   logic [CW-1:0]     col_q, col_d, col_eff;
   logic [RW-1:0]     row_q, row_d, row_eff;
   logic              out_valid_q, frame_done_q, sof_err_q;
   logic [WW-1:0]     im1_q, im2_q, im3_q;
   logic [PIX_W-1:0]  lb0_q [IMG_W];
   logic [PIX_W-1:0]  lb1_q [IMG_W];
   logic [PIX_W-1:0]  lb0_rd, lb1_rd;
   logic              accept, last_col, last_row, win_d;

   assign in_ready   = !out_valid_q || out_ready;
   assign out_valid  = out_valid_q;
   assign frame_done = frame_done_q;
   assign sof_err    = sof_err_q;
   assign im1        = im1_q;
   assign im2        = im2_q;
   assign im3        = im3_q;

   // A start-of-frame beat is positioned at (0,0) before any lookup or counting.
   always_comb begin
      accept   = in_valid && in_ready;
      col_eff  = in_sof ? '0 : col_q;
      row_eff  = in_sof ? '0 : row_q;
      lb0_rd   = lb0_q[col_eff];
      lb1_rd   = lb1_q[col_eff];
      last_col = (col_eff == CW'(IMG_W - 1));
      last_row = (row_eff == RW'(IMG_H - 1));
      col_d    = last_col ? '0 : col_eff + CW'(1);
      row_d    = row_eff;
      if (last_col) begin
         row_d = last_row ? '0 : row_eff + RW'(1);
      end
      win_d    = !in_sof && (state_q == STREAM) && (col_eff >= CW'(2));
   end

   // Line buffers: read-before-write, LB0 holds line r-1, LB1 holds line r-2.
   always_ff @(posedge clk) begin
      if (accept) begin
         lb0_q[col_eff] <= in_pix;
         lb1_q[col_eff] <= lb0_rd;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= PRIME;
         col_q        <= '0;
         row_q        <= '0;
         out_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
         sof_err_q    <= 1'b0;
         im1_q        <= '0;
         im2_q        <= '0;
         im3_q        <= '0;
      end else begin
         frame_done_q <= 1'b0;
         sof_err_q    <= 1'b0;
         if (accept) begin
            col_q        <= col_d;
            row_q        <= row_d;
            out_valid_q  <= win_d;
            im1_q        <= {im1_q[WW-PIX_W-1:0], lb1_rd};
            im2_q        <= {im2_q[WW-PIX_W-1:0], lb0_rd};
            im3_q        <= {im3_q[WW-PIX_W-1:0], in_pix};
            frame_done_q <= last_col && last_row;
            sof_err_q    <= in_sof && ((col_q != '0) || (row_q != '0));
            case (state_q)
               PRIME: begin
                  if (!in_sof && last_col && (row_eff == RW'(1))) begin
                     state_q <= STREAM;
                  end
               end
               STREAM: begin
                  if (in_sof || (last_col && last_row)) begin
                     state_q <= PRIME;
                  end
               end
               default: state_q <= PRIME;
            endcase
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_window_gen33.sv
// Directed self-checking bench for window_gen33 on a 4x4 frame, pixel = row*16+col.
module tb_window_gen33;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, in_sof;
   logic [15:0] in_pix;
   logic        out_valid, out_ready;
   logic [47:0] im1, im2, im3;
   logic        frame_done, sof_err;

   int pass_cnt  = 0;
   int fail_cnt  = 0;
   int total_cnt = 0;

   window_gen33 #(.PIX_W(16), .IMG_W(4), .IMG_H(4)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof), .in_pix(in_pix),
      .out_valid(out_valid), .out_ready(out_ready),
      .im1(im1), .im2(im2), .im3(im3),
      .frame_done(frame_done), .sof_err(sof_err)
   );

   always #5 clk = ~clk;

   function automatic logic [47:0] win(input int r, input int c);
      return {16'(r * 16 + c - 2), 16'(r * 16 + c - 1), 16'(r * 16 + c)};
   endfunction

   task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send(input int r, input int c, input logic sof);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_sof   = sof;
      in_pix   = 16'(r * 16 + c);
      @(negedge clk);
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("accept_wait", 48'(in_ready), 48'(1));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_sof   = 1'b0;
   endtask

   task automatic send_frame(input int r0, input int c0, input logic sof0,
                             input logic stall, input logic gap);
      int   nwin;
      logic stalled;
      nwin    = 0;
      stalled = 1'b0;
      for (int i = r0 * 4 + c0; i < 16; i++) begin
         int r;
         int c;
         r = i / 4;
         c = i % 4;
         send(r, c, sof0 && (i == 0));
         chk("out_valid", 48'(out_valid), 48'(r >= 2 && c >= 2));
         chk("frame_done", 48'(frame_done), 48'(i == 15));
         chk("sof_err", 48'(sof_err), 48'(0));
         if (out_valid) nwin++;
         if (r >= 2 && c >= 2) begin
            chk("im1", im1, win(r - 2, c));
            chk("im2", im2, win(r - 1, c));
            chk("im3", im3, win(r, c));
         end
         if (stall && !stalled && r >= 2 && c >= 2 && i < 15) begin
            stalled   = 1'b1;
            out_ready = 1'b0;
            in_valid  = 1'b1;
            in_pix    = 16'(((i + 1) / 4) * 16 + (i + 1) % 4);
            repeat (3) begin
               @(posedge clk);
               #1;
               chk("stall_in_ready", 48'(in_ready), 48'(0));
               chk("stall_valid", 48'(out_valid), 48'(1));
               chk("stall_im1", im1, win(r - 2, c));
               chk("stall_im2", im2, win(r - 1, c));
               chk("stall_im3", im3, win(r, c));
            end
            out_ready = 1'b1;
         end
         if (gap) begin
            @(posedge clk);
            #1;
         end
      end
      chk("win_count", 48'(nwin), 48'(4));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_sof    = 1'b0;
      in_pix    = '0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 48'(out_valid), 48'(0));
      chk("rst_frame_done", 48'(frame_done), 48'(0));
      chk("rst_sof_err", 48'(sof_err), 48'(0));
      chk("rst_in_ready", 48'(in_ready), 48'(1));
      chk("rst_im1", im1, 48'(0));
      chk("rst_im2", im2, 48'(0));
      chk("rst_im3", im3, 48'(0));
      rst = 1'b0;

      // Plain frame, then with backpressure, then with idle gaps between beats.
      send_frame(0, 0, 1'b1, 1'b0, 1'b0);
      send_frame(0, 0, 1'b1, 1'b1, 1'b0);
      send_frame(0, 0, 1'b1, 1'b0, 1'b1);

      // Misplaced start-of-frame at (1,2) restarts counting.
      for (int i = 0; i < 6; i++) begin
         send(i / 4, i % 4, i == 0);
         chk("pre_sof_valid", 48'(out_valid), 48'(0));
      end
      send(0, 0, 1'b1);
      chk("sof_err_pulse", 48'(sof_err), 48'(1));
      chk("sof_valid", 48'(out_valid), 48'(0));
      @(posedge clk);
      #1;
      chk("sof_err_clear", 48'(sof_err), 48'(0));
      send_frame(0, 1, 1'b0, 1'b0, 1'b0);

      // Reset while a window is pending, then a frame without in_sof.
      for (int i = 0; i < 11; i++) begin
         send(i / 4, i % 4, i == 0);
      end
      chk("pre_rst_valid", 48'(out_valid), 48'(1));
      chk("pre_rst_im3", im3, win(2, 2));
      out_ready = 1'b0;
      rst       = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_rst_valid", 48'(out_valid), 48'(0));
      chk("mid_rst_in_ready", 48'(in_ready), 48'(1));
      rst       = 1'b0;
      out_ready = 1'b1;
      send_frame(0, 0, 1'b0, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
